hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit_pkg.sv | 34 +++
 rtl/hazard_fwd_unit_if.sv | 25 ++
 rtl/hazard_shadow_pipe.sv | 29 ++
 rtl/hazard_fwd_unit.sv | 71 +++++++
 tb/tb_hazard_fwd_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the hazard/forwarding unit: forward-select codes, shadow stage
// records and the forward-priority helper.
package riscv_hazard_pkg;

    // Widest register index the shadow records can carry; narrower indices are zero-extended.
    localparam int REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    typedef struct packed {
        logic [REG_AW_MAX-1:0] rs1;
        logic [REG_AW_MAX-1:0] rs2;
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } e_stage_t;

    typedef struct packed {
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
    } wb_stage_t;

    // M wins over W; x0 is never a forwarding source.
    function automatic fwd_t fwd_sel(logic [REG_AW_MAX-1:0] rs, wb_stage_t m, wb_stage_t w);
        if (m.reg_write && m.rd != '0 && m.rd == rs) return FWD_MEM;
        if (w.reg_write && w.rd != '0 && w.rd == rs) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side request and hazard-control response bundle of hazard_fwd_unit.
interface hazard_fwd_if #(parameter int REG_AW = 5);
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic              RegWriteD;
    logic              MemReadD;
    logic              PCSrcE;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, MemReadD, PCSrcE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, MemReadD, PCSrcE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );
endinterface

// File: rtl/hazard_shadow_pipe.sv
// E/M/W shadow copies of the fields the hazard logic needs; E takes a bubble on flush,
// M and W always advance.
module hazard_shadow_pipe
    import riscv_hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_e,
    input  e_stage_t  d_stage,
    output e_stage_t  e_q,
    output wb_stage_t m_q,
    output wb_stage_t w_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (flush_e) e_q <= '0;
            else         e_q <= d_stage;
            m_q.rd        <= e_q.rd;
            m_q.reg_write <= e_q.reg_write;
            w_q           <= m_q;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding and load-use stall / branch flush control for a 5-stage pipeline.
// Optional load-use stall counter port enabled by defining HAZARD_STATS_EN.
module hazard_fwd_unit
    import riscv_hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_fwd_if.slave      hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    if (REG_AW > REG_AW_MAX || REG_AW < 1 || CNT_W < 1) begin : g_bad_params
        $error("hazard_fwd_unit: REG_AW must be 1..%0d and CNT_W >= 1", REG_AW_MAX);
    end

    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    e_stage_t          d_stage, e_q;
    wb_stage_t         m_q, w_q;
    logic              lw_stall;
    logic              flush_e;

    assign rs1_d = hz.Rs1D;
    assign rs2_d = hz.Rs2D;
    assign rd_d  = hz.RdD;

    always_comb begin
        d_stage           = '0;
        d_stage.rs1       = REG_AW_MAX'(rs1_d);
        d_stage.rs2       = REG_AW_MAX'(rs2_d);
        d_stage.rd        = REG_AW_MAX'(rd_d);
        d_stage.reg_write = hz.RegWriteD;
        d_stage.mem_read  = hz.MemReadD;
    end

    hazard_shadow_pipe u_shadow (
        .clk     (clk),
        .rst     (rst),
        .flush_e (flush_e),
        .d_stage (d_stage),
        .e_q     (e_q),
        .m_q     (m_q),
        .w_q     (w_q)
    );

    // A load sitting in M is not a forwarding source: only the shadow RegWrite/Rd are
    // kept there, and the one stall cycle already lets the load reach W.
    assign lw_stall = e_q.mem_read && (e_q.rd != '0) &&
                      ((e_q.rd == d_stage.rs1) || (e_q.rd == d_stage.rs2));
    assign flush_e  = lw_stall | hz.PCSrcE;

    assign hz.ForwardAE = fwd_sel(e_q.rs1, m_q, w_q);
    assign hz.ForwardBE = fwd_sel(e_q.rs2, m_q, w_q);
    assign hz.StallF    = lw_stall;
    assign hz.StallD    = lw_stall;
    assign hz.FlushD    = hz.PCSrcE;
    assign hz.FlushE    = flush_e;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                               stall_count <= '0;
        else if (lw_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed hazard scenarios plus randomized
// traffic against an instruction-history model.
module tb_hazard_fwd_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_fwd_if #(.REG_AW(REG_AW)) hif ();

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count;
`endif

    hazard_fwd_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    // One entry per instruction that entered execute; hist[0]=E, [1]=M, [2]=W.
    typedef struct packed {
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic              rw, mr;
    } ent_t;

    ent_t hist[$];
    int   model_cnt;
    int   checks = 0;
    int   passes = 0;

    function automatic logic [1:0] model_fwd(logic [REG_AW-1:0] rs);
        if (hist[1].rw && hist[1].rd != 0 && hist[1].rd == rs) return 2'b10;
        if (hist[2].rw && hist[2].rd != 0 && hist[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
    function automatic logic [7:0] model_out();
        logic lw;
        lw = hist[0].mr && hist[0].rd != 0 &&
             (hist[0].rd == hif.Rs1D || hist[0].rd == hif.Rs2D);
        return {model_fwd(hist[0].rs1), model_fwd(hist[0].rs2), lw, lw, hif.PCSrcE, lw | hif.PCSrcE};
    endfunction

    function automatic logic [7:0] outs();
        return {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.FlushD, hif.FlushE};
    endfunction

    task automatic drive(input int rs1, input int rs2, input int rd, input bit rw, input bit mr,
                         input bit pc);
        hif.Rs1D      = REG_AW'(rs1);
        hif.Rs2D      = REG_AW'(rs2);
        hif.RdD       = REG_AW'(rd);
        hif.RegWriteD = rw;
        hif.MemReadD  = mr;
        hif.PCSrcE    = pc;
        #1;
    endtask

    task automatic tick();
        logic [7:0] e;
        ent_t       nxt;
        e = model_out();
        if (rst) begin
            hist.delete();
            repeat (3) hist.push_back('0);
            model_cnt = 0;
        end else begin
            nxt = e[0] ? ent_t'('0) : ent_t'({hif.Rs1D, hif.Rs2D, hif.RdD, hif.RegWriteD, hif.MemReadD});
            if (e[3] && model_cnt < (1 << CNT_W) - 1) model_cnt++;
            hist.push_front(nxt);
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== 8'b00_00_0000) $display("FAIL reset_outs obs=%b exp=%b", outs(), 8'b0);
        else passes++;
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== '0) $display("FAIL reset_cnt obs=%0d exp=0", stall_count);
        else passes++;
`endif
    endtask

    task automatic test_fwd_mem();
        do_reset();
        drive(1, 2, 5, 1, 0, 0); tick();   // add x5,x1,x2
        drive(5, 1, 6, 1, 0, 0); tick();   // add x6,x5,x1
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== 8'b10_00_0000) $display("FAIL fwd_mem obs=%b exp=%b", outs(), 8'b10_00_0000);
        else passes++;
    endtask

    task automatic test_fwd_wb();
        do_reset();
        drive(3, 4, 7, 1, 0, 0);    tick(); // writer x7
        drive(10, 11, 12, 1, 0, 0); tick(); // unrelated
        drive(13, 7, 14, 1, 0, 0);  tick(); // consumer rs2=x7
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== 8'b00_01_0000) $display("FAIL fwd_wb obs=%b exp=%b", outs(), 8'b00_01_0000);
        else passes++;
        do_reset();
        drive(3, 4, 7, 1, 0, 0);   tick();  // writer x7 (ends in W)
        drive(3, 3, 7, 1, 0, 0);   tick();  // writer x7 (ends in M)
        drive(13, 7, 14, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== 8'b00_10_0000) $display("FAIL fwd_mem_prio obs=%b exp=%b", outs(), 8'b00_10_0000);
        else passes++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 8, 1, 1, 0); tick();    // lw x8
        drive(8, 8, 9, 1, 0, 0);            // add x9,x8,x8
        checks++;
        if (outs() !== 8'b00_00_1101) $display("FAIL lu_stall obs=%b exp=%b", outs(), 8'b00_00_1101);
        else passes++;
        tick();                             // IF/ID held, bubble into E
        checks++;
        if (outs() !== 8'b00_00_0000) $display("FAIL lu_bubble obs=%b exp=%b", outs(), 8'b0);
        else passes++;
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== CNT_W'(1)) $display("FAIL lu_cnt obs=%0d exp=1", stall_count);
        else passes++;
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== 8'b01_01_0000) $display("FAIL lu_fwd_wb obs=%b exp=%b", outs(), 8'b01_01_0000);
        else passes++;
    endtask

    task automatic test_x0();
        do_reset();
        drive(1, 2, 0, 1, 0, 0); tick();    // writes x0
        drive(0, 0, 10, 1, 0, 0); tick();   // consumer of x0
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== 8'b00_00_0000) $display("FAIL x0_fwd obs=%b exp=%b", outs(), 8'b0);
        else passes++;
        drive(3, 0, 0, 1, 1, 0); tick();    // lw x0
        drive(0, 0, 10, 1, 0, 0);
        checks++;
        if (outs() !== 8'b00_00_0000) $display("FAIL x0_lw obs=%b exp=%b", outs(), 8'b0);
        else passes++;
    endtask

    task automatic test_flush_stall();
        do_reset();
        drive(1, 0, 8, 1, 1, 0); tick();    // lw x8
        drive(8, 2, 9, 1, 0, 1);            // consumer + taken branch
        checks++;
        if (outs() !== 8'b00_00_1111) $display("FAIL flush_stall obs=%b exp=%b", outs(), 8'b00_00_1111);
        else passes++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== 8'b00_00_0000) $display("FAIL flush_bubble obs=%b exp=%b", outs(), 8'b0);
        else passes++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 0, 8, 1, 1, 0); tick();
        drive(8, 8, 9, 1, 0, 0);
        checks++;
        if (outs() !== 8'b00_00_1101) $display("FAIL rst_pre_stall obs=%b exp=%b", outs(), 8'b00_00_1101);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'b00_00_0000) $display("FAIL rst_mid_stall obs=%b exp=%b", outs(), 8'b0);
        else passes++;
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== '0) $display("FAIL rst_mid_cnt obs=%0d exp=0", stall_count);
        else passes++;
`endif
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            // Narrow index range so hazards are frequent.
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 60) == 0);
            #1;
            checks++;
            if (outs() !== model_out()) begin
                if (errs < 10) $display("FAIL rand_outs cyc=%0d obs=%b exp=%b", i, outs(), model_out());
                errs++;
            end else passes++;
`ifdef HAZARD_STATS_EN
            checks++;
            if (stall_count !== CNT_W'(model_cnt)) begin
                if (errs < 10) $display("FAIL rand_cnt cyc=%0d obs=%0d exp=%0d", i, stall_count, model_cnt);
                errs++;
            end else passes++;
`endif
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        hist.delete();
        repeat (3) hist.push_back('0);
        model_cnt = 0;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_load_use();
        test_x0();
        test_flush_stall();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
